gpio_in_port: RTL and testbench
===============================

# gpio_in_port

Memory-mapped GPIO input peripheral for the multi-cycle MIPS core, the input-side counterpart of the `GPIO_Out` path. Synchronises and debounces an 8-bit external input bus and latches rising edges into W1C sticky flags. Exposes the result as 32-bit words that the Data_Path reads through its normal memory address/data path (`lw`). Includes a maskable interrupt-request level.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bus width of `rd_data` and `wr_data`.
- `GPIO_WIDTH`, 8, number of input pins. Must be ≤ `DATA_WIDTH`.
- `BASE_ADDR`, 32'h1001_0040, word-aligned base of the 4-word register window.
- `DEBOUNCE_CYCLES`, 4, number of consecutive stable synchronised samples required before a bit changes. Must be ≥ 1.

Ports:
- `clk`, in, 1, single clock; all state on rising edge.
- `reset`, in, 1, asynchronous, active-low. Clears all state.
- `GPIO_In`, in, `GPIO_WIDTH`, asynchronous external pins.
- `addr`, in, `DATA_WIDTH`, byte address from the datapath. `addr[1:0]` is ignored.
- `wr_en`, in, 1, write strike for the current cycle.
- `wr_data`, in, `DATA_WIDTH`, write data.
- `rd_data`, out, `DATA_WIDTH`, combinational read data.
- `hit`, out, 1, combinational. High when `addr` decodes to one of the 4 registers; the datapath uses it to select `rd_data` over memory.
- `irq`, out, 1, level. Equals `|(EDGE & MASK)`.

## Operation
Register map (offset from `BASE_ADDR`); unused upper bits read 0:
- 0x0: DATA (RO), debounced pin value.
- 0x4: EDGE (RW1C), sticky rising-edge flags.
- 0x8: RAW (RO), 2-flop synchronised value, not debounced.
- 0xC: MASK (RW), irq enable per bit.

Per-bit pipeline:
- 2-flop synchroniser: `s1 <= GPIO_In`, `s2 <= s1`. RAW reads `s2`.
- Debounce counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - If `s2[i] == deb[i]`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `deb[i] <= s2[i]`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised samples never reaches `deb`. A return to equality resets the count.
- Edge detect: on the edge where `deb[i]` goes 0→1, `EDGE[i] <= 1`. Falling transitions set nothing.

Bus behaviour:
- Reads are combinational: `hit`/`rd_data` follow `addr` in the same cycle, and reads have no side effects.
- When `hit` = 0, `rd_data` = 0.
- Writes take effect on the rising edge with `wr_en && hit`:
  - EDGE: bits set in `wr_data` are cleared.
  - MASK: loaded from `wr_data[GPIO_WIDTH-1:0]`.
  - DATA/RAW: writes are ignored.
- Simultaneous set and clear of the same EDGE bit in one cycle: set wins (flag stays 1).
- `wr_en` with `hit` = 0: no state change.

## Timing
- Reset values: `s1`, `s2`, `deb`, `cnt`, EDGE and MASK are all 0. Consequently `irq` = 0; `rd_data` = 0 when `hit` = 0, and all registers read 0.
- Pin to RAW: 2 clocks.
- Pin to DATA: `2 + DEBOUNCE_CYCLES` clocks for a clean step (6 at default).
- EDGE bit and `irq` (if masked in) rise on the same edge that DATA rises.
- MASK write to `irq` update: visible right after the write edge, since `irq` is combinational from registers.
- EDGE clear to `irq` drop: 1 edge after the write.
- Reset asserted mid-count: `cnt`/`deb` clear immediately. After release, a held-high pin requires the full `2 + DEBOUNCE_CYCLES` again and then sets EDGE.
- Pins toggling every cycle: DATA never changes and EDGE is never set.

## Test plan
- Reset and idle:
  - Hold `reset`=0 with `GPIO_In`=8'hFF, then release → DATA=0, `irq`=0 at release.
  - DATA=8'hFF exactly 6 clocks after release.
  - EDGE=8'hFF.
- Debounce reject:
  - Pulse `GPIO_In[0]` high for 3 clocks → RAW shows the pulse; DATA and EDGE stay 0.
  - A 4-clock pulse → DATA[0]=1 on clock 6, EDGE[0]=1.
- W1C and set-wins:
  - With EDGE=8'h05, write 0x4 ← 32'h1 → EDGE=8'h04.
  - Write clearing bit 2 on the same edge bit 2 re-rises → EDGE[2] stays 1.
- Irq masking:
  - EDGE=8'h80, MASK=0 → `irq`=0.
  - Write MASK=8'h80 → `irq`=1 next cycle.
  - Clear EDGE → `irq`=0.
- Address decode:
  - `addr`=BASE+0x10 or BASE-4 → `hit`=0, `rd_data`=0; writes there leave MASK unchanged.
  - `addr`=BASE+0xE → reads MASK (low bits ignored).
- Reset mid-operation:
  - Assert `reset` on cycle 4 of a 6-cycle debounce → all state 0 immediately.
  - After release the pin still held high → DATA=1 after 6 further clocks.

Source files
------------

// File: rtl/gpio_in_port.sv
// Memory-mapped GPIO input port: 2-flop synchroniser, per-bit debounce, sticky
// W1C rising-edge flags and a maskable interrupt level, read through a 4-word window.
module gpio_in_port #(
   parameter int unsigned                  DATA_WIDTH      = 32,
   parameter int unsigned                  GPIO_WIDTH      = 8,
   parameter logic [DATA_WIDTH-1:0]        BASE_ADDR       = 32'h1001_0040,
   parameter int unsigned                  DEBOUNCE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [GPIO_WIDTH-1:0] GPIO_In,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  hit,
   output logic                  irq
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned WW = DATA_WIDTH - 2;
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] BASE_WORD = BASE_ADDR[DATA_WIDTH-1:2];

   localparam logic [1:0] OFF_DATA = 2'd0;
   localparam logic [1:0] OFF_EDGE = 2'd1;
   localparam logic [1:0] OFF_RAW  = 2'd2;
   localparam logic [1:0] OFF_MASK = 2'd3;

   logic [GPIO_WIDTH-1:0] r_s1;
   logic [GPIO_WIDTH-1:0] r_s2;
   logic [GPIO_WIDTH-1:0] r_deb;
   logic [GPIO_WIDTH-1:0] r_edge;
   logic [GPIO_WIDTH-1:0] r_mask;
   logic [CW-1:0]         r_cnt [GPIO_WIDTH];

   logic [WW-1:0]         w_word;
   logic [1:0]            w_sel;
   logic                  w_hit;
   logic                  w_wr_edge;
   logic                  w_wr_mask;
   logic [GPIO_WIDTH-1:0] w_clr;
   logic [GPIO_WIDTH-1:0] w_deb_nxt;
   logic [GPIO_WIDTH-1:0] w_rise;
   logic [GPIO_WIDTH-1:0] w_edge_nxt;
   logic [CW-1:0]         w_cnt_nxt [GPIO_WIDTH];
   logic                  w_unused;

   // Word offset relative to the window base; wraps for addresses below it.
   assign w_word    = addr[DATA_WIDTH-1:2] - BASE_WORD;
   assign w_hit     = (w_word < WW'(4));
   assign w_sel     = w_word[1:0];
   assign w_wr_edge = wr_en & w_hit & (w_sel == OFF_EDGE);
   assign w_wr_mask = wr_en & w_hit & (w_sel == OFF_MASK);
   assign w_unused  = ^{addr[1:0], wr_data};

   assign hit = w_hit;
   assign irq = |(r_edge & r_mask);

   always_comb begin
      rd_data = '0;
      if (w_hit) begin
         case (w_sel)
            OFF_DATA: rd_data = DATA_WIDTH'(r_deb);
            OFF_EDGE: rd_data = DATA_WIDTH'(r_edge);
            OFF_RAW:  rd_data = DATA_WIDTH'(r_s2);
            OFF_MASK: rd_data = DATA_WIDTH'(r_mask);
            default:  rd_data = '0;
         endcase
      end
   end

   // A bit flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
   always_comb begin
      w_deb_nxt = r_deb;
      for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
         w_cnt_nxt[i] = '0;
         if (r_s2[i] != r_deb[i]) begin
            if (r_cnt[i] == CNT_MAX) begin
               w_deb_nxt[i] = r_s2[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Set beats clear when both hit the same flag on one edge.
   assign w_rise     = w_deb_nxt & ~r_deb;
   assign w_clr      = w_wr_edge ? wr_data[GPIO_WIDTH-1:0] : '0;
   assign w_edge_nxt = (r_edge & ~w_clr) | w_rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_deb  <= '0;
         r_edge <= '0;
         r_mask <= '0;
         for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_s1   <= GPIO_In;
         r_s2   <= r_s1;
         r_deb  <= w_deb_nxt;
         r_edge <= w_edge_nxt;
         if (w_wr_mask) begin
            r_mask <= wr_data[GPIO_WIDTH-1:0];
         end
         for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_gpio_in_port.sv
// Bench for gpio_in_port: sample-window behavioural model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_gpio_in_port;

   localparam logic [31:0] BASE = 32'h1001_0040;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  gpio;
   logic [31:0] addr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        hit;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   gpio_in_port #(
      .DATA_WIDTH      (32),
      .GPIO_WIDTH      (8),
      .BASE_ADDR       (BASE),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .GPIO_In (gpio),
      .addr    (addr),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .hit     (hit),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // Model state: pins delayed twice, then a bit follows the sync value once the
   // last four synchronised samples all disagree with the current debounced value.
   logic [7:0] m_s1, m_s2, m_deb, m_edge, m_mask, m_nd, m_clr;
   logic [3:0] m_hist [8];

   function automatic logic m_hit(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'd16);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] off;
      if (!m_hit(a)) return 32'h0;
      off = (a - BASE) / 4;
      case (off)
         0:       return {24'h0, m_deb};
         1:       return {24'h0, m_edge};
         2:       return {24'h0, m_s2};
         default: return {24'h0, m_mask};
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1 = 0; m_s2 = 0; m_deb = 0; m_edge = 0; m_mask = 0;
         for (int i = 0; i < 8; i++) m_hist[i] = 4'h0;
      end else begin
         m_nd = m_deb;
         for (int i = 0; i < 8; i++) begin
            m_hist[i] = {m_hist[i][2:0], m_s2[i]};
            if (m_hist[i] == (m_deb[i] ? 4'b0000 : 4'b1111)) m_nd[i] = ~m_deb[i];
         end
         m_clr = 8'h0;
         if (wr_en && m_hit(addr)) begin
            if ((addr - BASE) / 4 == 1) m_clr = wr_data[7:0];
            if ((addr - BASE) / 4 == 3) m_mask = wr_data[7:0];
         end
         m_edge = (m_edge & ~m_clr) | (m_nd & ~m_deb);
         m_deb  = m_nd;
         m_s2   = m_s1;
         m_s1   = gpio;
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #2;
      chk("model_hit", 32'(hit), 32'(m_hit(addr)));
      chk("model_rd_data", rd_data, m_read(addr));
      chk("model_irq", 32'(irq), 32'(|(m_edge & m_mask)));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic settle(input int n);
      repeat (n) tick();
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk);
      addr = a;
      #3;
      chk(nm, rd_data, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr    = a;
      wr_data = d;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; gpio = 8'hFF; addr = BASE; wr_en = 1'b0; wr_data = 32'h0;
      settle(3);
      chk("rst_data", rd_data, 32'h0);
      reset = 1'b1;
      #3;
      chk("rel_data", rd_data, 32'h0);
      chk("rel_irq", 32'(irq), 32'h0);
      for (int k = 1; k <= 6; k++) begin
         tick(); #3;
         chk($sformatf("pwr_data_k%0d", k), rd_data, (k == 6) ? 32'hFF : 32'h0);
      end
      rd_chk("pwr_edge", BASE + 4, 32'hFF);
      chk("pwr_irq", 32'(irq), 32'h0);

      gpio = 8'h00; wr(BASE + 4, 32'hFF); settle(8);
      rd_chk("idle_edge", BASE + 4, 32'h0);

      // 3-sample glitch: visible on RAW, rejected by the debouncer
      addr = BASE + 8;
      for (int k = 0; k < 10; k++) begin
         gpio = (k < 3) ? 8'h01 : 8'h00;
         tick(); #3;
         chk($sformatf("p3_raw_k%0d", k), rd_data, (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
      end
      rd_chk("p3_data", BASE, 32'h0);
      rd_chk("p3_edge", BASE + 4, 32'h0);

      addr = BASE;
      for (int k = 0; k < 12; k++) begin
         gpio = (k < 4) ? 8'h01 : 8'h00;
         tick(); #3;
         chk($sformatf("p4_data_k%0d", k), rd_data, (k >= 5 && k <= 8) ? 32'h1 : 32'h0);
      end
      rd_chk("p4_edge", BASE + 4, 32'h1);

      gpio = 8'h04; settle(7); gpio = 8'h00; settle(7);
      rd_chk("w1c_pre", BASE + 4, 32'h5);
      wr(BASE + 4, 32'h1);
      rd_chk("w1c", BASE + 4, 32'h4);
      wr(BASE + 4, 32'h4);
      rd_chk("w1c_b2", BASE + 4, 32'h0);

      // Clear lands on the same edge bit 2 debounces high
      gpio = 8'h04; settle(5);
      wr(BASE + 4, 32'h4); #3;
      chk("set_wins", rd_data, 32'h4);

      gpio = 8'h00; settle(8); wr(BASE + 4, 32'hFF);
      gpio = 8'h80; settle(8);
      rd_chk("irq_edge", BASE + 4, 32'h80);
      chk("irq_masked", 32'(irq), 32'h0);
      wr(BASE + 12, 32'h80); #3;
      chk("irq_on", 32'(irq), 32'h1);
      wr(BASE + 4, 32'h80); #3;
      chk("irq_off", 32'(irq), 32'h0);

      rd_chk("oob_hi_rd", BASE + 16, 32'h0);
      chk("oob_hi_hit", 32'(hit), 32'h0);
      rd_chk("oob_lo_rd", BASE - 4, 32'h0);
      chk("oob_lo_hit", 32'(hit), 32'h0);
      wr(BASE + 16, 32'h0);
      wr(BASE - 4, 32'h0);
      rd_chk("mask_keep", BASE + 14, 32'h80);
      chk("mask_hit", 32'(hit), 32'h1);
      wr(BASE + 12, 32'hFFFF_FF81);
      rd_chk("mask_upper", BASE + 12, 32'h81);
      wr(BASE + 12, 32'h80);

      // Reset during the fourth cycle of a debounce
      gpio = 8'h00; settle(8);
      addr = BASE; gpio = 8'h01; settle(4);
      reset = 1'b0;
      #1; chk("mid_rst_data", rd_data, 32'h0);
      addr = BASE + 12;
      #1; chk("mid_rst_mask", rd_data, 32'h0);
      addr = BASE + 8;
      #1; chk("mid_rst_raw", rd_data, 32'h0);
      tick();
      reset = 1'b1; addr = BASE;
      for (int k = 1; k <= 6; k++) begin
         tick(); #3;
         chk($sformatf("mid_data_k%0d", k), rd_data, (k == 6) ? 32'h1 : 32'h0);
      end
      rd_chk("mid_edge", BASE + 4, 32'h1);

      gpio = 8'h00; settle(8); wr(BASE + 4, 32'hFF);
      addr = BASE;
      for (int k = 0; k < 20; k++) begin
         gpio = (k % 2 == 1) ? 8'hFF : 8'h00;
         tick();
      end
      rd_chk("tog_data", BASE, 32'h0);
      rd_chk("tog_edge", BASE + 4, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
